// File: rtl/gf_inv_array_param_if.sv
// Streaming bus for the GF(2^m) inversion engine: input batch, field config and output stream.
interface gf_inv_array_param_if #(
  parameter int unsigned M_MAX = 8,
  parameter int unsigned DW    = $clog2(M_MAX + 1)
);
  logic             in_valid;
  logic             in_ready;
  logic [M_MAX-1:0] in_data;
  logic [DW-1:0]    deg;
  logic [M_MAX:0]   poly;
  logic             out_valid;
  logic             out_ready;
  logic [M_MAX-1:0] out_data;

  modport master (
    output in_valid, in_data, deg, poly, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, deg, poly, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/gf_inv_array_param.sv
// Batch GF(2^m) inverter: loads N elements, inverts each by Fermat (a^(2^m-2)) using
// a sequential square-and-multiply, then streams the results in input order.
module gf_inv_array_param #(
  parameter int unsigned M_MAX = 8,
  parameter int unsigned N     = 6,
  parameter int unsigned DW    = $clog2(M_MAX + 1)
) (
  input logic                clk,
  input logic                rst,
  gf_inv_array_param_if.slave bus
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(N - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StCalc, StOut} state_e;

  state_e           r_state, w_state_next;
  logic [M_MAX-1:0] r_buf [N];
  logic [IW-1:0]    r_idx;
  logic [DW-1:0]    r_step;
  logic [DW-1:0]    r_deg;
  logic [M_MAX:0]   r_poly;
  logic [M_MAX-1:0] r_sq, r_acc;
  logic             r_out_valid;
  logic [M_MAX-1:0] r_out_data;

  logic             w_in_ready;
  logic [DW-1:0]    w_step_last;
  logic [IW-1:0]    w_idx_inc;
  logic             w_idx_last;
  logic             w_step_end;
  logic [M_MAX-1:0] w_sq_cur, w_acc_cur, w_sq_next, w_acc_next;

  function automatic logic [M_MAX-1:0] deg_mask(input logic [DW-1:0] m);
    logic [M_MAX-1:0] mk;
    mk = '0;
    for (int i = 0; i < int'(M_MAX); i++) begin
      if (i < int'(m)) mk[i] = 1'b1;
    end
    return mk;
  endfunction

  // Carry-less product, then fold every bit >= m back with poly aligned under it.
  function automatic logic [M_MAX-1:0] gf_mul(input logic [M_MAX-1:0] a,
                                              input logic [M_MAX-1:0] b,
                                              input logic [M_MAX:0]   p,
                                              input logic [DW-1:0]    m);
    logic [2*M_MAX-2:0] prod, av, pw;
    prod = '0;
    av   = '0;
    av[M_MAX-1:0] = a;
    for (int j = 0; j < int'(M_MAX); j++) begin
      if (b[j]) prod = prod ^ (av << j);
    end
    pw = '0;
    pw[M_MAX:0] = p;
    for (int i = int'(2 * M_MAX - 2); i >= 0; i--) begin
      if ((i >= int'(m)) && prod[i]) prod = prod ^ (pw << (i - int'(m)));
    end
    return prod[M_MAX-1:0] & deg_mask(m);
  endfunction

  // Illegal degrees below 2 still spend one cycle per element so the batch always finishes.
  assign w_step_last = (r_deg < DW'(2)) ? '0 : r_deg - DW'(2);
  assign w_step_end  = (r_step == w_step_last);
  assign w_idx_inc   = r_idx + IW'(1);
  assign w_idx_last  = (r_idx == LastIdx);

  // First step of an element seeds sq=a, acc=1 without spending an extra cycle.
  assign w_sq_cur   = (r_step == '0) ? r_buf[r_idx] : r_sq;
  assign w_acc_cur  = (r_step == '0) ? M_MAX'(1) : r_acc;
  assign w_sq_next  = gf_mul(w_sq_cur, w_sq_cur, r_poly, r_deg);
  assign w_acc_next = gf_mul(w_acc_cur, w_sq_next, r_poly, r_deg);

  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (bus.in_valid) w_state_next = (N == 1) ? StCalc : StLoad;
      StLoad: begin
        if (!bus.in_valid)   w_state_next = StIdle;
        else if (w_idx_last) w_state_next = StCalc;
      end
      StCalc: if (w_idx_last && w_step_end) w_state_next = StOut;
      StOut:  if (r_out_valid && bus.out_ready && w_idx_last) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_in_ready = (r_state == StIdle) || (r_state == StLoad);
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(N); i++) r_buf[i] <= '0;
      r_idx       <= '0;
      r_step      <= '0;
      r_deg       <= '0;
      r_poly      <= '0;
      r_sq        <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.in_valid) begin
            r_deg    <= bus.deg;
            r_poly   <= bus.poly;
            r_buf[0] <= bus.in_data & deg_mask(bus.deg);
            r_idx    <= (N == 1) ? '0 : IW'(1);
            r_step   <= '0;
          end
        end
        StLoad: begin
          if (bus.in_valid) begin
            r_buf[r_idx] <= bus.in_data & deg_mask(r_deg);
            r_idx        <= w_idx_last ? '0 : w_idx_inc;
          end else begin
            r_idx <= '0;
          end
        end
        StCalc: begin
          r_sq  <= w_sq_next;
          r_acc <= w_acc_next;
          if (w_step_end) begin
            r_buf[r_idx] <= w_acc_next;
            r_step       <= '0;
            r_idx        <= w_idx_last ? '0 : w_idx_inc;
          end else begin
            r_step <= r_step + DW'(1);
          end
        end
        StOut: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_buf[r_idx];
          end else if (bus.out_ready) begin
            if (w_idx_last) begin
              r_out_valid <= 1'b0;
              r_out_data  <= '0;
              r_idx       <= '0;
            end else begin
              r_idx      <= w_idx_inc;
              r_out_data <= r_buf[w_idx_inc];
            end
          end
        end
        default: r_idx <= '0;
      endcase
    end
  end

endmodule

// File: doc/gf_inv_array_param.md
Name: gf_inv_array_param

Overview:
- Parametrised successor to the fixed 5-bit GF inverse array. Accepts a batch of N field elements together with a runtime-selected degree and irreducible polynomial, and computes each multiplicative inverse in GF(2^deg).
- Returns the inverses in input order over a ready/valid output handshake.
- Sits in the security/attack datapath as the shared GF inversion engine, for field degrees 2..M_MAX.

Parameters:
- M_MAX, 8, maximum field degree; data width is M_MAX bits.
- N, 6, elements per batch (>=1).
- DW, $clog2(M_MAX+1), width of the deg field.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid; must stay high for N consecutive cycles per batch.
- in_ready  out  1  high only in IDLE/LOAD; a sample is taken when in_valid && in_ready.
- in_data  in  M_MAX  field element, LSB = x^0.
- deg  in  DW  field degree m, 2..M_MAX; sampled on the first element only.
- poly  in  M_MAX+1  irreducible polynomial, bit m set; sampled on the first element only.
- out_valid  out  1  output element valid.
- out_ready  in  1  downstream accept.
- out_data  out  M_MAX  inverse; bits >= m are zero.

Behaviour:
- Reset (rst=1 at an edge):
  - All state is cleared; FSM goes to IDLE; batch buffer is zeroed.
  - Outputs after reset: out_valid=0, out_data=0, in_ready=1.
  - Reset mid-operation discards the batch, with no partial output.
- FSM states: IDLE -> LOAD -> CALC -> OUT -> IDLE.
- IDLE / LOAD:
  - The first handshake latches deg and poly, stores element 0 and enters LOAD.
  - Each following handshake stores the next element in buffer index order.
  - The handshake that stores element N-1 moves the FSM to CALC.
  - If in_valid drops before N elements have been taken, the batch is aborted and the FSM returns to IDLE; no output.
  - in_data bits >= m are masked to zero on capture.
- CALC:
  - in_ready=0; in_valid is ignored.
  - Fermat inversion: a^-1 = a^(2^m - 2).
  - Per element: sq<=a, acc<=1. Then for i=1..m-1, one cycle each: sq<=sq^2 mod poly; acc<=acc*sq_next mod poly.
  - Each element takes exactly m-1 cycles; the result overwrites its buffer slot.
  - Elements are processed index 0..N-1; total CALC time is N*(m-1) cycles.
  - Multiply and square are single-cycle combinational GF multipliers: carry-less product followed by reduction by poly, truncated to m bits.
  - Inverse of 0 is defined as 0 (falls out of Fermat; no special case needed, but it is verified).
- OUT:
  - out_valid first rises exactly N*(m-1)+1 cycles after the edge that sampled element N-1.
  - out_data = buffer[k], k = 0..N-1, registered.
  - k advances only on out_valid && out_ready. While out_ready=0, out_valid and out_data are held stable.
  - After the handshake on element N-1: out_valid=0 on the next cycle, FSM to IDLE, in_ready=1 on the same cycle.
  - No overlap: a new batch is never accepted while in CALC or OUT.
- Width rules:
  - Internal product width is 2*M_MAX-1.
  - Reduction iterates from bit 2*M_MAX-2 down to bit m, XORing poly shifted into place wherever that bit is set.
- Illegal configuration (deg<2, deg>M_MAX, or poly[m]=0): behaviour undefined, but the block must not hang. It still completes the fixed cycle count N*max(m-1,1) and emits N outputs.

Test Plan:
- Basic GF(2^5) case, reference config: M_MAX=8, N=6, deg=5, poly=0x25.
  - Stimulus: data 1,2,0,1,2,0; out_ready=1.
  - Required: out_data 1,0x12,0,1,0x12,0; first out_valid 25 cycles after the last input sample.
- Small degree, m-1=1 cycle per element: deg=3, poly=0xB, data 1..6.
  - Required: out_data 1,5,6,7,2,3 (pairs 2↔5, 3↔6, 4↔7).
- AES field: deg=8, poly=0x11B, data 0x53 (+ 0x01, 0x02, 0x03, 0xCA, 0x00).
  - Required: 0xCA, 0x01, 0x8D, 0xF6, 0x53, 0x00.
  - CALC lasts 42 cycles.
- deg=2 with backpressure: deg=2, poly=0x7, data 2,3,1,0,2,3.
  - Stimulus: out_ready toggled 1,0,0,1,… during OUT.
  - Required: outputs 3,2,1,0,3,2; out_data/out_valid stable while out_ready=0; in_ready=0 until the final handshake.
- Masking and aborted batch:
  - in_data=0xE2 with deg=5 → treated as 0x02, output 0x12.
  - in_valid dropped after 3 samples → no out_valid; the next full batch is processed correctly.
- Reset and ignored input during CALC: assert rst in mid-CALC, and separately drive in_valid during CALC.
  - Required after reset: out_valid=0, out_data=0, in_ready=1; no stale output appears.
  - Required for in_valid during CALC: it is ignored, and the buffer contents are unchanged.
